// File: rtl/avalon_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : avalon_bus_arbiter
// Description : Two-master, one-slave Avalon-MM arbiter. Grants one transfer
//               at a time and holds the grant through slave waitrequest.
// Revision    : 1.0 - initial release
// ============================================================================
module avalon_bus_arbiter #(
    parameter int FIXED_PRIORITY = 0
) (
    input  logic        clk,
    input  logic        reset,

    input  logic [31:0] m0_address,
    input  logic        m0_read,
    input  logic        m0_write,
    input  logic [31:0] m0_writedata,
    input  logic [3:0]  m0_byteenable,
    output logic        m0_waitrequest,
    output logic [31:0] m0_readdata,

    input  logic [31:0] m1_address,
    input  logic        m1_read,
    input  logic        m1_write,
    input  logic [31:0] m1_writedata,
    input  logic [3:0]  m1_byteenable,
    output logic        m1_waitrequest,
    output logic [31:0] m1_readdata,

    output logic [31:0] s_address,
    output logic        s_read,
    output logic        s_write,
    output logic [31:0] s_writedata,
    output logic [3:0]  s_byteenable,
    input  logic        s_waitrequest,
    input  logic [31:0] s_readdata,

    output logic [1:0]  grant
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    state_t r_state;
    state_t w_next;
    logic   r_last;
    logic   w_last_next;
    logic   w_req0;
    logic   w_req1;

    assign w_req0 = m0_read | m0_write;
    assign w_req1 = m1_read | m1_write;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_last  <= 1'b1;
        end else begin
            r_state <= w_next;
            r_last  <= w_last_next;
        end
    end

    always_comb begin
        w_next      = r_state;
        w_last_next = r_last;
        case (r_state)
            IDLE: begin
                if (w_req0 && w_req1) begin
                    // Tie: fixed priority favours m0, otherwise alternate away from last owner
                    if ((FIXED_PRIORITY != 0) || r_last) begin
                        w_next      = OWN0;
                        w_last_next = 1'b0;
                    end else begin
                        w_next      = OWN1;
                        w_last_next = 1'b1;
                    end
                end else if (w_req0) begin
                    w_next      = OWN0;
                    w_last_next = 1'b0;
                end else if (w_req1) begin
                    w_next      = OWN1;
                    w_last_next = 1'b1;
                end
            end
            OWN0: if (!w_req0 || !s_waitrequest) w_next = IDLE;
            OWN1: if (!w_req1 || !s_waitrequest) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        s_address      = 32'd0;
        s_read         = 1'b0;
        s_write        = 1'b0;
        s_writedata    = 32'd0;
        s_byteenable   = 4'd0;
        m0_waitrequest = 1'b1;
        m1_waitrequest = 1'b1;
        grant          = 2'b00;
        case (r_state)
            OWN0: begin
                s_address      = m0_address;
                s_read         = m0_read;
                s_write        = m0_write;
                s_writedata    = m0_writedata;
                s_byteenable   = m0_byteenable;
                m0_waitrequest = s_waitrequest;
                grant          = 2'b01;
            end
            OWN1: begin
                s_address      = m1_address;
                s_read         = m1_read;
                s_write        = m1_write;
                s_writedata    = m1_writedata;
                s_byteenable   = m1_byteenable;
                m1_waitrequest = s_waitrequest;
                grant          = 2'b10;
            end
            default: ;
        endcase
    end

    // Read data is broadcast; only the owner's waitrequest qualifies it
    assign m0_readdata = s_readdata;
    assign m1_readdata = s_readdata;

endmodule
`default_nettype wire

// File: tb/tb_avalon_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_avalon_bus_arbiter
// Description : Directed self-checking bench, round-robin and fixed-priority.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_avalon_bus_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] m0_address, m1_address;
    logic        m0_read, m0_write, m1_read, m1_write;
    logic [31:0] m0_writedata, m1_writedata;
    logic [3:0]  m0_byteenable, m1_byteenable;
    logic        s_waitrequest;
    logic [31:0] s_readdata;

    logic        rr_m0_wait, rr_m1_wait, fp_m0_wait, fp_m1_wait;
    logic [31:0] rr_m0_rd, rr_m1_rd, fp_m0_rd, fp_m1_rd;
    logic [31:0] rr_s_addr, fp_s_addr, rr_s_wd, fp_s_wd;
    logic        rr_s_read, rr_s_write, fp_s_read, fp_s_write;
    logic [3:0]  rr_s_be, fp_s_be;
    logic [1:0]  rr_grant, fp_grant;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    avalon_bus_arbiter #(.FIXED_PRIORITY(0)) dut_rr (
        .clk(clk), .reset(reset),
        .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
        .m0_writedata(m0_writedata), .m0_byteenable(m0_byteenable),
        .m0_waitrequest(rr_m0_wait), .m0_readdata(rr_m0_rd),
        .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
        .m1_writedata(m1_writedata), .m1_byteenable(m1_byteenable),
        .m1_waitrequest(rr_m1_wait), .m1_readdata(rr_m1_rd),
        .s_address(rr_s_addr), .s_read(rr_s_read), .s_write(rr_s_write),
        .s_writedata(rr_s_wd), .s_byteenable(rr_s_be),
        .s_waitrequest(s_waitrequest), .s_readdata(s_readdata),
        .grant(rr_grant)
    );

    avalon_bus_arbiter #(.FIXED_PRIORITY(1)) dut_fp (
        .clk(clk), .reset(reset),
        .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
        .m0_writedata(m0_writedata), .m0_byteenable(m0_byteenable),
        .m0_waitrequest(fp_m0_wait), .m0_readdata(fp_m0_rd),
        .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
        .m1_writedata(m1_writedata), .m1_byteenable(m1_byteenable),
        .m1_waitrequest(fp_m1_wait), .m1_readdata(fp_m1_rd),
        .s_address(fp_s_addr), .s_read(fp_s_read), .s_write(fp_s_write),
        .s_writedata(fp_s_wd), .s_byteenable(fp_s_be),
        .s_waitrequest(s_waitrequest), .s_readdata(s_readdata),
        .grant(fp_grant)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        m0_address = 32'd0; m0_read = 1'b0; m0_write = 1'b0;
        m0_writedata = 32'd0; m0_byteenable = 4'd0;
        m1_address = 32'd0; m1_read = 1'b0; m1_write = 1'b0;
        m1_writedata = 32'd0; m1_byteenable = 4'd0;
        s_waitrequest = 1'b0; s_readdata = 32'd0;
    endtask

    task automatic apply_reset();
        clear_inputs();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        // Inputs driven while idle must not leak to the slave
        m0_address = 32'h1234_5678; m0_writedata = 32'hFFFF_FFFF; m0_byteenable = 4'hF;
        n_tests++;
        if ({rr_grant, rr_s_read, rr_s_write, rr_s_addr, rr_s_wd, rr_s_be, rr_m0_wait, rr_m1_wait}
            !== {2'b00, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0, 1'b1, 1'b1}) begin
            n_fail++;
            $display("FAIL reset_idle_rr: grant=%b rd=%b wr=%b addr=%h wd=%h be=%b w0=%b w1=%b, required idle values",
                     rr_grant, rr_s_read, rr_s_write, rr_s_addr, rr_s_wd, rr_s_be, rr_m0_wait, rr_m1_wait);
        end
        n_tests++;
        if ({fp_grant, fp_s_read, fp_s_addr, fp_m0_wait, fp_m1_wait} !== {2'b00, 1'b0, 32'd0, 1'b1, 1'b1}) begin
            n_fail++;
            $display("FAIL reset_idle_fp: grant=%b rd=%b addr=%h w0=%b w1=%b, required idle values",
                     fp_grant, fp_s_read, fp_s_addr, fp_m0_wait, fp_m1_wait);
        end
        clear_inputs();
    endtask

    task automatic test_single_read();
        apply_reset();
        m0_read = 1'b1; m0_address = 32'h0000_1000; s_waitrequest = 1'b0;
        s_readdata = 32'hCAFE_F00D;
        n_tests++;
        if ({rr_grant, rr_s_read} !== {2'b00, 1'b0}) begin
            n_fail++;
            $display("FAIL read_latency: grant=%b s_read=%b, required 00 0", rr_grant, rr_s_read);
        end
        tick();
        n_tests++;
        if ({rr_grant, rr_s_read, rr_s_addr, rr_m0_wait, rr_m1_wait} !== {2'b01, 1'b1, 32'h1000, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL read_granted: grant=%b s_read=%b addr=%h w0=%b w1=%b, required 01 1 00001000 0 1",
                     rr_grant, rr_s_read, rr_s_addr, rr_m0_wait, rr_m1_wait);
        end
        n_tests++;
        if ({rr_m0_rd, rr_m1_rd} !== {32'hCAFE_F00D, 32'hCAFE_F00D}) begin
            n_fail++;
            $display("FAIL readdata_route: m0=%h m1=%h, required cafef00d cafef00d", rr_m0_rd, rr_m1_rd);
        end
        m0_read = 1'b0;
        tick();
        n_tests++;
        if ({rr_grant, rr_s_read, rr_m0_wait} !== {2'b00, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL read_done_idle: grant=%b s_read=%b w0=%b, required 00 0 1", rr_grant, rr_s_read, rr_m0_wait);
        end
    endtask

    task automatic test_wait_write();
        apply_reset();
        m1_write = 1'b1; m1_address = 32'h20; m1_writedata = 32'hDEAD_BEEF;
        m1_byteenable = 4'b0011; s_waitrequest = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            if (i == 3) begin
                s_waitrequest = 1'b0;
                #1;
            end
            n_tests++;
            if ({rr_grant, rr_s_write, rr_s_read, rr_s_addr, rr_s_wd, rr_s_be, rr_m1_wait, rr_m0_wait}
                !== {2'b10, 1'b1, 1'b0, 32'h20, 32'hDEAD_BEEF, 4'b0011, s_waitrequest, 1'b1}) begin
                n_fail++;
                $display("FAIL wait_write_cyc%0d: grant=%b wr=%b addr=%h wd=%h be=%b w1=%b w0=%b, required 10 1 00000020 deadbeef 0011 %b 1",
                         i, rr_grant, rr_s_write, rr_s_addr, rr_s_wd, rr_s_be, rr_m1_wait, rr_m0_wait, s_waitrequest);
            end
            if (i < 3) tick();
        end
        m1_write = 1'b0;
        tick();
        n_tests++;
        if ({rr_grant, rr_s_write, rr_m1_wait} !== {2'b00, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL wait_write_idle: grant=%b wr=%b w1=%b, required 00 0 1", rr_grant, rr_s_write, rr_m1_wait);
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0] exp_rr [7];
        logic [1:0] exp_fp [7];
        exp_rr[0] = 2'b01; exp_rr[1] = 2'b00; exp_rr[2] = 2'b10; exp_rr[3] = 2'b00;
        exp_rr[4] = 2'b01; exp_rr[5] = 2'b00; exp_rr[6] = 2'b10;
        exp_fp[0] = 2'b01; exp_fp[1] = 2'b00; exp_fp[2] = 2'b01; exp_fp[3] = 2'b00;
        exp_fp[4] = 2'b01; exp_fp[5] = 2'b00; exp_fp[6] = 2'b01;
        apply_reset();
        m0_read = 1'b1; m0_address = 32'h100;
        m1_read = 1'b1; m1_address = 32'h200;
        s_waitrequest = 1'b0;
        for (int i = 0; i < 7; i++) begin
            tick();
            n_tests++;
            if (rr_grant !== exp_rr[i]) begin
                n_fail++;
                $display("FAIL b2b_rr_cyc%0d: grant=%b, required %b", i, rr_grant, exp_rr[i]);
            end
            n_tests++;
            if ({fp_grant, fp_m1_wait} !== {exp_fp[i], 1'b1}) begin
                n_fail++;
                $display("FAIL b2b_fp_cyc%0d: grant=%b w1=%b, required %b 1", i, fp_grant, fp_m1_wait, exp_fp[i]);
            end
        end
        n_tests++;
        if ({rr_s_addr, rr_m1_wait, rr_m0_wait} !== {32'h200, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL b2b_rr_route: addr=%h w1=%b w0=%b, required 00000200 0 1", rr_s_addr, rr_m1_wait, rr_m0_wait);
        end
        clear_inputs();
    endtask

    task automatic test_reset_mid_transfer();
        apply_reset();
        m0_read = 1'b1; m0_address = 32'h40; s_waitrequest = 1'b1;
        tick();
        n_tests++;
        if ({rr_grant, rr_s_read} !== {2'b01, 1'b1}) begin
            n_fail++;
            $display("FAIL midrst_own0: grant=%b s_read=%b, required 01 1", rr_grant, rr_s_read);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_tests++;
        if ({rr_grant, rr_s_read, rr_m0_wait, rr_m1_wait} !== {2'b00, 1'b0, 1'b1, 1'b1}) begin
            n_fail++;
            $display("FAIL midrst_idle: grant=%b s_read=%b w0=%b w1=%b, required 00 0 1 1",
                     rr_grant, rr_s_read, rr_m0_wait, rr_m1_wait);
        end
        tick();
        n_tests++;
        if ({rr_grant, rr_s_read, rr_m0_wait} !== {2'b01, 1'b1, 1'b1}) begin
            n_fail++;
            $display("FAIL midrst_regrant: grant=%b s_read=%b w0=%b, required 01 1 1", rr_grant, rr_s_read, rr_m0_wait);
        end
        clear_inputs();
    endtask

    task automatic test_withdraw();
        apply_reset();
        m1_read = 1'b1; m1_address = 32'h80; s_waitrequest = 1'b1;
        tick();
        n_tests++;
        if (rr_grant !== 2'b10) begin
            n_fail++;
            $display("FAIL withdraw_own1: grant=%b, required 10", rr_grant);
        end
        m1_read = 1'b0;
        m0_read = 1'b1; m0_address = 32'h90;
        #1;
        n_tests++;
        if ({rr_m0_wait, rr_s_read, rr_s_addr} !== {1'b1, 1'b0, 32'h80}) begin
            n_fail++;
            $display("FAIL withdraw_pending: w0=%b s_read=%b addr=%h, required 1 0 00000080", rr_m0_wait, rr_s_read, rr_s_addr);
        end
        tick();
        n_tests++;
        if (rr_grant !== 2'b00) begin
            n_fail++;
            $display("FAIL withdraw_idle: grant=%b, required 00", rr_grant);
        end
        tick();
        n_tests++;
        if ({rr_grant, rr_s_addr} !== {2'b01, 32'h90}) begin
            n_fail++;
            $display("FAIL withdraw_m0_grant: grant=%b addr=%h, required 01 00000090", rr_grant, rr_s_addr);
        end
        clear_inputs();
    endtask

    task automatic test_read_write_both();
        apply_reset();
        m1_read = 1'b1; m1_write = 1'b1; m1_writedata = 32'hA5A5_0F0F; m1_byteenable = 4'b1100;
        s_waitrequest = 1'b1;
        tick();
        n_tests++;
        if ({rr_grant, rr_s_read, rr_s_write, rr_s_wd, rr_s_be} !== {2'b10, 1'b1, 1'b1, 32'hA5A5_0F0F, 4'b1100}) begin
            n_fail++;
            $display("FAIL rw_both: grant=%b rd=%b wr=%b wd=%h be=%b, required 10 1 1 a5a50f0f 1100",
                     rr_grant, rr_s_read, rr_s_write, rr_s_wd, rr_s_be);
        end
        clear_inputs();
    endtask

    initial begin
        reset = 1'b1;
        clear_inputs();
        test_reset();
        test_single_read();
        test_wait_write();
        test_back_to_back();
        test_reset_mid_transfer();
        test_withdraw();
        test_read_write_both();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/avalon_bus_arbiter.md
Name: avalon_bus_arbiter

Overview:
- Two-master, one-slave arbiter for the Avalon memory-mapped bus that the CPU core drives.
- Shares the single memory port between master 0 (the CPU bus interface) and master 1 (a loader/debug or DMA master).
- Grants the bus one transfer at a time.
- Holds each grant through slave waitrequest stalls, so the waitrequest semantics seen by every master are unchanged.

Parameters:
- FIXED_PRIORITY, 0, 0 = round-robin on ties; 1 = master 0 always wins ties.

Ports:
- clk  input  1  system clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- m0_address  input  32  master 0 byte address
- m0_read  input  1  master 0 read request
- m0_write  input  1  master 0 write request
- m0_writedata  input  32  master 0 write data
- m0_byteenable  input  4  master 0 byte lanes
- m0_waitrequest  output  1  master 0 stall
- m0_readdata  output  32  master 0 read data
- m1_address, m1_read, m1_write, m1_writedata, m1_byteenable, m1_waitrequest, m1_readdata: same widths, directions and meanings as the m0_ ports, for master 1
- s_address  output  32  slave address
- s_read  output  1  slave read strobe
- s_write  output  1  slave write strobe
- s_writedata  output  32  slave write data
- s_byteenable  output  4  slave byte lanes
- s_waitrequest  input  1  slave stall
- s_readdata  input  32  slave read data
- grant  output  2  one-hot current owner (bit0 = m0, bit1 = m1); 2'b00 when idle

Behaviour:
- Request definition: reqN = mN_read | mN_write.
- State register values: IDLE, OWN0, OWN1.
- last register: index of the most recently granted master.
- Reset (synchronous): state = IDLE, last = 1. Every output takes its IDLE value in the cycle after reset is sampled high.
  - IDLE outputs: s_read = s_write = 0, s_address = 0, s_writedata = 0, s_byteenable = 0, grant = 0, m0_waitrequest = m1_waitrequest = 1.
- IDLE transitions:
  - Only req0 → OWN0, last <= 0.
  - Only req1 → OWN1, last <= 1.
  - Both requesting:
    - FIXED_PRIORITY = 1 → OWN0.
    - Otherwise, grant the master != last.
  - Neither requesting → stay in IDLE.
- Arbitration latency: exactly one cycle. A request first asserted in cycle T reaches the slave no earlier than cycle T+1.
- OWNx, combinational pass-through:
  - s_* = mx_* (address, read, write, writedata, byteenable).
  - mx_waitrequest = s_waitrequest; the other master's waitrequest = 1.
  - grant = one-hot x.
- Read data: s_readdata is routed to both m0_readdata and m1_readdata. It is valid only to the owning master when its waitrequest = 0.
- Transfer completes in any OWNx cycle with reqx = 1 and s_waitrequest = 0. Next state is IDLE. This gives one dead cycle between transfers, so back-to-back requests alternate under round-robin.
- OWNx with s_waitrequest = 1: hold OWNx indefinitely, with no timeout. mx_* must stay stable per Avalon rules; the arbiter does not latch them.
- OWNx with reqx = 0 (protocol violation, master withdrew): next state IDLE, no transfer counted.
- Reset asserted mid-transfer: IDLE next cycle regardless of s_waitrequest. The slave sees its strobes drop.
- Simultaneous read and write from one master: both strobes are passed through unchanged; the arbiter does not resolve this.
- A non-owning master's request is never lost. It stays pending, with waitrequest = 1, until granted.

Test Plan:
- Reset, then m0_read = 1, m0_address = 0x1000, s_waitrequest = 0 → cycle+1: grant = 01, s_read = 1, s_address = 0x1000, m0_waitrequest = 0; cycle+2: IDLE, grant = 00, m0_waitrequest = 1.
- m1_write = 1, m1_address = 0x20, m1_writedata = 0xDEADBEEF, m1_byteenable = 4'b0011, s_waitrequest high for 3 cycles → grant = 10 held 4 cycles, s_writedata = 0xDEADBEEF and s_byteenable = 0011 stable throughout, m1_waitrequest tracks s_waitrequest, m0_waitrequest = 1.
- Both masters read continuously, FIXED_PRIORITY = 0, s_waitrequest = 0 → grant sequence 01,00,10,00,01,00,10 (m0 first after reset).
- Same stimulus, FIXED_PRIORITY = 1 → grant sequence 01,00,01,00…; m1_waitrequest stays 1 throughout.
- OWN0 with s_waitrequest = 1, reset pulsed for one cycle → next cycle s_read = 0, grant = 00, both waitrequests = 1; after reset drops, m0 is re-granted within 1 cycle.
- OWN1 with s_waitrequest = 1, m1_read dropped to 0 → next cycle IDLE; pending m0 request is granted the following cycle.
